id_issue_ctrl: RTL and testbench

//  Parametrised issue/hazard controller that sits beside the decode stage and drives the ID/EX register enable.

---
 rtl/id_issue_ctrl_pkg.sv | 12 +
 rtl/id_issue_ctrl_if.sv | 37 +++
 rtl/id_issue_ctrl_scoreboard.sv | 74 +++++++
 rtl/id_issue_ctrl.sv | 72 +++++++
 tb/tb_id_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the decode-side issue/hazard controller.
package id_issue_ctrl_pkg;
  localparam int DEF_REG_W      = 6;
  localparam int DEF_FWD_STAGES = 2;
  localparam int DEF_SB_DEPTH   = 4;
  localparam int DEF_LAT_W      = 5;

  // Forward-select encoding: 0 reads the regfile, k forwards from downstream stage k.
  localparam int FWD_FROM_RF    = 0;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode/hazard bundle between the decode stage (master) and the issue controller (slave).
interface id_issue_ctrl_if #(
  parameter int REG_W      = 6,
  parameter int FWD_STAGES = 2,
  parameter int LAT_W      = 5
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);

  logic                        id_vld;
  logic [REG_W-1:0]            id_rs1;
  logic [REG_W-1:0]            id_rs2;
  logic [REG_W-1:0]            id_rd;
  logic                        id_long;
  logic [LAT_W-1:0]            id_lat;
  logic                        flush;
  logic [FWD_STAGES-1:0]       stg_vld;
  logic [FWD_STAGES*REG_W-1:0] stg_rd;
  logic [FWD_STAGES-1:0]       stg_load;
  logic [FSEL_W-1:0]           forw_rs1;
  logic [FSEL_W-1:0]           forw_rs2;
  logic                        stall;
  logic                        issue;
  logic                        sb_full;
  logic [31:0]                 stall_cnt;

  modport master (
    output id_vld, id_rs1, id_rs2, id_rd, id_long, id_lat, flush,
           stg_vld, stg_rd, stg_load,
    input  forw_rs1, forw_rs2, stall, issue, sb_full, stall_cnt
  );

  modport slave (
    input  id_vld, id_rs1, id_rs2, id_rd, id_long, id_lat, flush,
           stg_vld, stg_rd, stg_load,
    output forw_rs1, forw_rs2, stall, issue, sb_full, stall_cnt
  );
endinterface

// File: rtl/id_issue_ctrl_scoreboard.sv
// Scoreboard of in-flight multi-cycle ops: per-entry latency countdown, hit query, lowest-free allocation.
module issue_scoreboard #(
  parameter int REG_W    = 6,
  parameter int SB_DEPTH = 4,
  parameter int LAT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] q_rs1,
  input  logic [REG_W-1:0] q_rs2,
  input  logic [REG_W-1:0] q_rd,
  input  logic             alloc,
  input  logic [REG_W-1:0] alloc_rd,
  input  logic [LAT_W-1:0] alloc_lat,
  output logic             hit,
  output logic             full
);
  localparam int IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  logic [SB_DEPTH-1:0] ent_vld;
  logic [LAT_W-1:0]    ent_cnt [SB_DEPTH];
  logic [REG_W-1:0]    ent_rd  [SB_DEPTH];
  logic [IDX_W-1:0]    free_idx;
  logic                any_free;

  // Descending scan so the lowest-index free entry is the one left selected.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ent_vld[i] && ((q_rs1 != '0 && ent_rd[i] == q_rs1) ||
                         (q_rs2 != '0 && ent_rd[i] == q_rs2) ||
                         (q_rd  != '0 && ent_rd[i] == q_rd)))
        hit = 1'b1;
    end
  end

  assign full = !any_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld <= '0;
      for (int i = 0; i < SB_DEPTH; i++) ent_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (ent_vld[i]) begin
          ent_cnt[i] <= ent_cnt[i] - LAT_W'(1);
          if (ent_cnt[i] == LAT_W'(1)) ent_vld[i] <= 1'b0;
        end
        if (alloc && any_free && free_idx == IDX_W'(i)) begin
          ent_vld[i] <= 1'b1;
          ent_cnt[i] <= alloc_lat;
        end
      end
    end
  end

  // Destination ids are payload only; validity is carried by ent_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (alloc && any_free && free_idx == IDX_W'(i)) ent_rd[i] <= alloc_rd;
    end
  end
endmodule

// File: rtl/id_issue_ctrl.sv
// Issue/hazard controller beside decode: forwarding select, load-use and scoreboard stalls, stall counter.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_W      = DEF_REG_W,
  parameter int FWD_STAGES = DEF_FWD_STAGES,
  parameter int SB_DEPTH   = DEF_SB_DEPTH,
  parameter int LAT_W      = DEF_LAT_W
) (
  input  logic           clk,
  input  logic           rst,
  id_issue_ctrl_if.slave bus
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);

  logic [FSEL_W-1:0] fwd1, fwd2;
  logic              load_use, sb_hit, sb_full, stall_raw, go, alloc;
  logic [31:0]       stall_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 32'd1;
  endfunction

  // Oldest stage first so a younger match overwrites it and wins.
  always_comb begin
    fwd1 = FSEL_W'(FWD_FROM_RF);
    fwd2 = FSEL_W'(FWD_FROM_RF);
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (bus.stg_vld[k] && bus.id_rs1 != '0 && bus.stg_rd[k*REG_W +: REG_W] == bus.id_rs1)
        fwd1 = FSEL_W'(k + 1);
      if (bus.stg_vld[k] && bus.id_rs2 != '0 && bus.stg_rd[k*REG_W +: REG_W] == bus.id_rs2)
        fwd2 = FSEL_W'(k + 1);
    end
  end

  assign load_use = bus.stg_vld[0] && bus.stg_load[0] && bus.stg_rd[REG_W-1:0] != '0 &&
                    (bus.stg_rd[REG_W-1:0] == bus.id_rs1 || bus.stg_rd[REG_W-1:0] == bus.id_rs2);

  assign stall_raw = load_use || sb_hit || (bus.id_long && sb_full);
  assign go        = rst && bus.id_vld && !bus.flush;

  assign bus.stall    = go && stall_raw;
  assign bus.issue    = go && !stall_raw;
  assign bus.forw_rs1 = rst ? fwd1 : '0;
  assign bus.forw_rs2 = rst ? fwd2 : '0;
  assign bus.sb_full  = sb_full;
  assign alloc        = bus.issue && bus.id_long && bus.id_rd != '0;

  issue_scoreboard #(
    .REG_W    (REG_W),
    .SB_DEPTH (SB_DEPTH),
    .LAT_W    (LAT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .q_rs1     (bus.id_rs1),
    .q_rs2     (bus.id_rs2),
    .q_rd      (bus.id_rd),
    .alloc     (alloc),
    .alloc_rd  (bus.id_rd),
    .alloc_lat (bus.id_lat),
    .hit       (sb_hit),
    .full      (sb_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           stall_cnt_q <= '0;
    else if (bus.stall) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl with an expectation queue checked on the falling edge.
module tb_id_issue_ctrl;
  import id_issue_ctrl_pkg::*;

  localparam int REG_W = 6, FWD_STAGES = 2, SB_DEPTH = 4, LAT_W = 5;
  localparam int S_F1 = 0, S_F2 = 1, S_STALL = 2, S_ISSUE = 3, S_FULL = 4, S_CNT = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;
  bit          exp_stall = 1'b0;

  id_issue_ctrl_if #(.REG_W(REG_W), .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) bus ();

  id_issue_ctrl #(
    .REG_W(REG_W), .FWD_STAGES(FWD_STAGES), .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_F1:    return 32'(bus.forw_rs1);
      S_F2:    return 32'(bus.forw_rs2);
      S_STALL: return 32'(bus.stall);
      S_ISSUE: return 32'(bus.issue);
      S_FULL:  return 32'(bus.sb_full);
      default: return bus.stall_cnt;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sbq.push_back(e);
    if (sel == S_STALL) exp_stall = v[0];
  endtask

  task automatic push_si(string tag, bit st, bit is);
    push({tag, ".stall"}, S_STALL, 32'(st));
    push({tag, ".issue"}, S_ISSUE, 32'(is));
  endtask

  task automatic compare_all();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      n_tests++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic check();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step();
    @(posedge clk);
    if (exp_stall) exp_cnt = (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
    #1;
  endtask

  task automatic set_id(bit vld, int rs1, int rs2, int rd, bit lng, int lat, bit fl);
    bus.id_vld  = vld;
    bus.id_rs1  = REG_W'(rs1);
    bus.id_rs2  = REG_W'(rs2);
    bus.id_rd   = REG_W'(rd);
    bus.id_long = lng;
    bus.id_lat  = LAT_W'(lat);
    bus.flush   = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stg_vld  = 2'b11;
    bus.stg_rd   = {6'd5, 6'd5};
    bus.stg_load = 2'b00;
    set_id(1, 5, 0, 0, 0, 0, 0);
    exp_stall = 1'b0;

    // Reset holds every output low even with a matching stage
    push("rst.fwd1", S_F1, 0);
    push_si("rst", 0, 0);
    push("rst.full", S_FULL, 0);
    push("rst.cnt", S_CNT, 0);
    check();
    rst = 1'b1;
    step();

    // Forwarding priority
    push("fwd.both", S_F1, 1);
    push_si("fwd.both", 0, 1);
    check(); step();
    bus.stg_vld = 2'b10;
    push("fwd.s2", S_F1, 2);
    push_si("fwd.s2", 0, 1);
    check(); step();
    set_id(1, 0, 0, 0, 0, 0, 0);
    push("fwd.x0", S_F1, 0);
    push_si("fwd.x0", 0, 1);
    check(); step();

    // Load-use in stage 1 stalls, in stage 2 forwards
    bus.stg_vld  = 2'b01;
    bus.stg_load = 2'b01;
    bus.stg_rd   = {6'd0, 6'd7};
    set_id(1, 0, 7, 0, 0, 0, 0);
    push("ldu.s1.fwd2", S_F2, 1);
    push_si("ldu.s1", 1, 0);
    check(); step();
    bus.stg_vld  = 2'b10;
    bus.stg_load = 2'b10;
    bus.stg_rd   = {6'd7, 6'd0};
    push("ldu.s2.fwd2", S_F2, 2);
    push_si("ldu.s2", 0, 1);
    push("ldu.cnt", S_CNT, exp_cnt);
    check(); step();

    // Long op: DIV rd=9 lat=3, consumer stalls exactly three cycles
    bus.stg_vld  = 2'b00;
    bus.stg_load = 2'b00;
    set_id(1, 1, 2, 9, 1, 3, 0);
    push_si("div.issue", 0, 1);
    check(); step();
    set_id(1, 9, 0, 10, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      push_si($sformatf("raw.c%0d", c), 1, 0);
      check(); step();
    end
    push_si("raw.c4", 0, 1);
    push("raw.cnt", S_CNT, exp_cnt);
    check(); step();

    // Fill the scoreboard, then full / independent / WAW / RAW cases
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 0, 11 + i, 1, 10, 0);
      push($sformatf("fill%0d.full", i), S_FULL, 0);
      push_si($sformatf("fill%0d", i), 0, 1);
      check(); step();
    end
    set_id(1, 0, 0, 15, 1, 10, 0);
    push("full.flag", S_FULL, 1);
    push_si("full.long", 1, 0);
    check(); step();
    set_id(1, 0, 0, 16, 0, 0, 0);
    push_si("full.indep", 0, 1);
    check(); step();
    set_id(1, 0, 0, 12, 0, 0, 0);
    push_si("waw", 1, 0);
    check(); step();
    set_id(1, 0, 0, 12, 1, 4, 0);
    push_si("waw.long", 1, 0);
    check(); step();
    set_id(1, 13, 0, 17, 0, 0, 0);
    push_si("raw.pend", 1, 0);
    push("fill.cnt", S_CNT, exp_cnt);
    check(); step();

    // Flush overrides a hit
    set_id(1, 11, 0, 20, 1, 10, 1);
    push_si("flush.hit", 0, 0);
    check(); step();

    // Drain all entries
    set_id(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      push_si("drain", 0, 0);
      check(); step();
    end
    push("drain.full", S_FULL, 0);
    check(); step();

    // Flush must not allocate
    set_id(1, 0, 0, 21, 1, 20, 0);
    push_si("a21", 0, 1);
    check(); step();
    set_id(1, 21, 0, 22, 1, 5, 1);
    push_si("flush.noalloc", 0, 0);
    check(); step();
    set_id(1, 22, 0, 23, 0, 0, 0);
    push_si("flush.rd22free", 0, 1);
    check(); step();
    set_id(1, 21, 0, 0, 0, 0, 0);
    push_si("a21.pend", 1, 0);
    check(); step();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 0, 24 + i, 1, 20, 0);
      push_si($sformatf("refill%0d", i), 0, 1);
      check(); step();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    push("refill.full", S_FULL, 1);
    push("refill.cnt", S_CNT, exp_cnt);
    push_si("refill.idle", 0, 0);
    check();

    // Asynchronous reset mid-countdown clears state immediately
    #2 rst = 1'b0;
    #1;
    push("arst.full", S_FULL, 0);
    push("arst.cnt", S_CNT, 0);
    compare_all();
    exp_cnt = '0;
    #1 rst = 1'b1;
    set_id(1, 21, 0, 0, 0, 0, 0);
    push_si("arst.clear", 0, 1);
    check(); step();

    // Saturation via preloaded counter under a sustained load-use stall
    bus.stg_vld  = 2'b01;
    bus.stg_load = 2'b01;
    bus.stg_rd   = {6'd0, 6'd7};
    set_id(1, 7, 0, 0, 0, 0, 0);
    push_si("sat.stall", 1, 0);
    check();
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    step();
    push("sat.reach", S_CNT, exp_cnt);
    push_si("sat.stall2", 1, 0);
    check(); step();
    push("sat.hold", S_CNT, 32'hFFFF_FFFF);
    check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
